// File: rtl/phase_step_pkg.sv
// Shared definitions for the phase step controller.
// Holds the FSM state encoding, the eight-entry phase pattern ring and
// the step sizes used to walk that ring.
package phase_step_pkg;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned PH_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE_S = 2'd2
    } state_e;

    // Pattern bits are {P1,P2,P3,P4}. Entry 0 sits in the low nibble.
    localparam logic [7:0][PH_W-1:0] PHASE_PATTERN = {
        4'b1001,   // 7
        4'b0001,   // 6
        4'b0011,   // 5
        4'b0010,   // 4
        4'b0110,   // 3
        4'b0100,   // 2
        4'b1100,   // 1
        4'b1000    // 0
    };

    localparam logic [IDX_W-1:0] STEP_FULL = IDX_W'(2);
    localparam logic [IDX_W-1:0] STEP_HALF = IDX_W'(1);

    // Index arithmetic wraps naturally mod 8. Full steps keep index parity,
    // so an odd start stays on the two-phase entries.
    function automatic logic [IDX_W-1:0] next_index(
        input logic [IDX_W-1:0] idx,
        input logic             fwd,
        input logic             half
    );
        logic [IDX_W-1:0] step;
        step = half ? STEP_HALF : STEP_FULL;
        return fwd ? (idx + step) : (idx - step);
    endfunction

endpackage

// File: rtl/phase_step_controller_prescaler.sv
// phase_prescaler: step-rate divider.
// Counts 0..div while enabled and flags tick_c in the cycle the count equals
// div, then wraps to 0. div = 0 therefore ticks every enabled cycle.
// Ports:
//   clk, rst_n : clock and async active-low reset
//   clr        : synchronous clear to 0 (dominates en)
//   en         : count enable
//   div        : terminal count
//   tick_c     : combinational terminal-count flag
module phase_prescaler #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick_c
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    // Next count: clear wins, otherwise wrap at terminal count.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == div) ? '0 : (count_q + DIV_W'(1));
        end
    end

    assign tick_c = en && !clr && (count_q == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/phase_step_controller.sv
// phase_step_controller: four-phase sequencer for a stepper / LED phase ring.
// A START in IDLE latches the rate divider, step count and step mode, then
// the block walks an 8-entry pattern ring one entry (half) or two entries
// (full) per prescaler tick, in the direction given by DIR at each tick.
// STEPS = 0 runs until STOP; otherwise the run ends with a one-cycle DONE.
// Optional build macro PHASE_HOLD_EN: when defined, the last pattern stays
// driven in IDLE; when undefined the phase outputs are 0000 in IDLE.
// Ports:
//   C_IN, CLR_N     : clock (rising edge), async active-low reset
//   START, STOP     : run request (IDLE only) and abort
//   DIR, HALF_STEP  : direction (1 = forward) and step mode
//   DIV, STEPS      : step period minus one, step count (0 = continuous)
//   BUSY, DONE      : running flag, counted-run completion pulse
//   Phase1..Phase4  : registered phase drive
module phase_step_controller
    import phase_step_pkg::*;
#(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             C_IN,
    input  logic             CLR_N,
    input  logic             START,
    input  logic             STOP,
    input  logic             DIR,
    input  logic             HALF_STEP,
    input  logic [DIV_W-1:0] DIV,
    input  logic [CNT_W-1:0] STEPS,
    output logic             BUSY,
    output logic             DONE,
    output logic             Phase1,
    output logic             Phase2,
    output logic             Phase3,
    output logic             Phase4
);

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   index_q,     index_d;
    logic [DIV_W-1:0]   div_q,       div_d;
    logic               half_q,      half_d;
    logic               counted_q,   counted_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic [PH_W-1:0]    phase_q,     phase_d;

    logic               presc_clr_c;
    logic               presc_en_c;
    logic               tick_c;

    // Prescaler is held at 0 outside RUN so every run starts a full period.
    assign presc_clr_c = (state_q != RUN);
    assign presc_en_c  = (state_q == RUN);

    phase_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (C_IN),
        .rst_n  (CLR_N),
        .clr    (presc_clr_c),
        .en     (presc_en_c),
        .div    (div_q),
        .tick_c (tick_c)
    );

    // Next-state, index, counter and output computation.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        div_d       = div_q;
        half_d      = half_q;
        counted_d   = counted_q;
        remaining_d = remaining_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        phase_d     = '0;

        case (state_q)
            IDLE: begin
                // STOP dominates a coincident START.
                if (START && !STOP) begin
                    state_d     = RUN;
                    div_d       = DIV;
                    half_d      = HALF_STEP;
                    counted_d   = (STEPS != '0);
                    remaining_d = STEPS;
                end
            end
            RUN: begin
                // An abort suppresses any step that would tick this cycle.
                if (STOP) begin
                    state_d = IDLE;
                end else if (tick_c) begin
                    index_d = next_index(index_q, DIR, half_q);
                    if (counted_q) begin
                        remaining_d = remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_d = DONE_S;
                        end
                    end
                end
            end
            DONE_S: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE_S);

        // Phase register tracks the index it will hold after this edge, so a
        // step shows up on the outputs the cycle after its tick.
        if ((state_d == RUN) || (state_d == DONE_S)) begin
            phase_d = PHASE_PATTERN[index_d];
        end else begin
`ifdef PHASE_HOLD_EN
            phase_d = PHASE_PATTERN[index_d];
`else
            phase_d = '0;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge C_IN or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q     <= IDLE;
            index_q     <= '0;
            div_q       <= '0;
            half_q      <= 1'b0;
            counted_q   <= 1'b0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            phase_q     <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            div_q       <= div_d;
            half_q      <= half_d;
            counted_q   <= counted_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            phase_q     <= phase_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign Phase1 = phase_q[3];
    assign Phase2 = phase_q[2];
    assign Phase3 = phase_q[1];
    assign Phase4 = phase_q[0];

endmodule

// File: tb/tb_phase_step_controller.sv
// Directed scoreboard bench for phase_step_controller.
// Expected phase patterns are produced by a small index model when a run is
// started and popped as each step becomes visible on the outputs.
module tb_phase_step_controller;

    logic        C_IN;
    logic        CLR_N;
    logic        start;
    logic        stop;
    logic        dir;
    logic        half_step;
    logic [15:0] div;
    logic [15:0] steps;
    logic        busy;
    logic        done;
    logic        p1, p2, p3, p4;

    int          n_cmp;
    int          n_err;
    int          done_cnt;
    int          midx;
    logic [3:0]  exp_q[$];

    phase_step_controller #(
        .DIV_W (16),
        .CNT_W (16)
    ) dut (
        .C_IN      (C_IN),
        .CLR_N     (CLR_N),
        .START     (start),
        .STOP      (stop),
        .DIR       (dir),
        .HALF_STEP (half_step),
        .DIV       (div),
        .STEPS     (steps),
        .BUSY      (busy),
        .DONE      (done),
        .Phase1    (p1),
        .Phase2    (p2),
        .Phase3    (p3),
        .Phase4    (p4)
    );

    initial C_IN = 1'b0;
    always #5 C_IN = ~C_IN;

    always @(negedge C_IN) begin
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [3:0] pat(input int i);
        case (i)
            0: return 4'b1000;
            1: return 4'b1100;
            2: return 4'b0100;
            3: return 4'b0110;
            4: return 4'b0010;
            5: return 4'b0011;
            6: return 4'b0001;
            default: return 4'b1001;
        endcase
    endfunction

    function automatic int nxt(input int i, input bit fwd, input bit half);
        int s;
        s = half ? 1 : 2;
        return fwd ? ((i + s) % 8) : ((i + 8 - s) % 8);
    endfunction

    function automatic logic [3:0] ph();
        return {p1, p2, p3, p4};
    endfunction

    function automatic logic [3:0] idle_pat();
`ifdef PHASE_HOLD_EN
        return pat(midx);
`else
        return 4'b0000;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; pulses START, checks BUSY rise and queues steps.
    task automatic start_run(input int d, input int n, input bit fwd, input bit half, input int nq);
        div       = 16'(d);
        steps     = 16'(n);
        dir       = fwd;
        half_step = half;
        start     = 1'b1;
        @(negedge C_IN);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("start_phase", ph(), pat(midx));
        for (int k = 0; k < nq; k++) begin
            midx = nxt(midx, fwd, half);
            exp_q.push_back(pat(midx));
        end
    endtask

    // Waits one step period, then compares the next scoreboard entry.
    task automatic step_check(input int d, input bit last, input string tag);
        logic [3:0] e;
        repeat (d + 1) @(negedge C_IN);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, ph(), e);
        end
        chk({tag, "_done"}, done, last);
        chk({tag, "_busy"}, busy, !last);
    endtask

    task automatic idle_check(input string tag);
        @(negedge C_IN);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_phase"}, ph(), idle_pat());
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        done_cnt  = 0;
        midx      = 0;
        CLR_N     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        dir       = 1'b1;
        half_step = 1'b0;
        div       = 16'd0;
        steps     = 16'd0;

        // Reset held for three cycles.
        repeat (3) @(negedge C_IN);
        chk("rst_phase", ph(), 4'b0000);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        CLR_N = 1'b1;
        @(negedge C_IN);
        chk("post_rst_phase", ph(), 4'b0000);
        chk("post_rst_busy", busy, 0);

        // Forward full-step counted run, one step per cycle.
        start_run(0, 4, 1'b1, 1'b0, 4);
        step_check(0, 1'b0, "fwd_s1");
        step_check(0, 1'b0, "fwd_s2");
        step_check(0, 1'b0, "fwd_s3");
        step_check(0, 1'b1, "fwd_s4");
        idle_check("fwd_end");
        chk("fwd_done_cnt", done_cnt, 1);

        // Reverse half-step with divider; DONE lands 12 cycles after BUSY.
        start_run(3, 3, 1'b0, 1'b1, 3);
        step_check(3, 1'b0, "rev_s1");
        step_check(3, 1'b0, "rev_s2");
        step_check(3, 1'b1, "rev_s3");
        idle_check("rev_end");
        chk("rev_done_cnt", done_cnt, 2);

        // Continuous run, five steps in ten cycles, then STOP.
        start_run(1, 0, 1'b1, 1'b0, 5);
        for (int k = 0; k < 5; k++) step_check(1, 1'b0, "cont_s");
        stop = 1'b1;
        idle_check("cont_stop");
        stop = 1'b0;
        chk("cont_done_cnt", done_cnt, 2);

        // START and STOP together in IDLE: stays idle.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge C_IN);
        start = 1'b0;
        stop  = 1'b0;
        chk("coll_busy", busy, 0);
        idle_check("coll_idle");

        // START with a new STEPS during RUN is ignored; run length stays 3.
        start_run(0, 3, 1'b1, 1'b1, 3);
        start = 1'b1;
        steps = 16'd10;
        step_check(0, 1'b0, "poke_s1");
        start = 1'b0;
        step_check(0, 1'b0, "poke_s2");
        step_check(0, 1'b1, "poke_s3");
        idle_check("poke_end");
        chk("poke_done_cnt", done_cnt, 3);

        // Async reset between edges at step 2 of 5.
        start_run(3, 5, 1'b1, 1'b0, 5);
        step_check(3, 1'b0, "arst_s1");
        step_check(3, 1'b0, "arst_s2");
        #2 CLR_N = 1'b0;
        #1;
        chk("arst_phase", ph(), 4'b0000);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        exp_q.delete();
        midx = 0;
        repeat (2) @(negedge C_IN);
        CLR_N = 1'b1;
        repeat (8) @(negedge C_IN);
        chk("arst_busy_after", busy, 0);
        chk("arst_done_cnt", done_cnt, 3);

        // Index restarts from 0 after reset.
        start_run(0, 1, 1'b1, 1'b1, 1);
        step_check(0, 1'b1, "final_s1");
        idle_check("final_end");
        chk("final_done_cnt", done_cnt, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
